// File: rtl/btm_arb.sv
// btm_arb: round-robin arbiter feeding one shared btm approximate multiplier.
// Requests are granted round-robin, the winner's operands enter a stallable
// result pipeline, and products leave on one response channel tagged by ID.
// Optional: define BTM_ARB_STATS_EN to add saturating stall/grant counters
// (o_stall_cnt, o_gnt_cnt).
module btm_arb #(
  parameter int unsigned BWOP = 32,
  parameter int unsigned NAB  = 1,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,  // 2**IDW must cover NREQ
  parameter int unsigned LAT  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req_vld,
  input  logic [NREQ*BWOP-1:0] i_req_a,
  input  logic [NREQ*BWOP-1:0] i_req_b,
  output logic [NREQ-1:0]      o_req_rdy,
  output logic                 o_rsp_vld,
  output logic [IDW-1:0]       o_rsp_id,
  output logic [BWOP-1:0]      o_rsp_c,
  input  logic                 i_rsp_rdy
`ifdef BTM_ARB_STATS_EN
  ,
  output logic [15:0]          o_stall_cnt,
  output logic [NREQ*16-1:0]   o_gnt_cnt
`endif
);

  // Product width wide enough that no shift or multiply loses low bits
  localparam int unsigned PW = 2 * BWOP + 2;

  logic                stall_c;
  logic                accept_c;
  logic [NREQ-1:0]     gnt_c;
  logic [IDW-1:0]      gnt_idx_c;
  int unsigned         best_dist_c;
  logic [BWOP-1:0]     sel_a_c;
  logic [BWOP-1:0]     sel_b_c;

  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      ptr_d;

  logic                s0_vld_q;
  logic [IDW-1:0]      s0_id_q;
  logic [BWOP-1:0]     s0_a_q;
  logic [BWOP-1:0]     s0_b_q;

  logic [BWOP-1:0]     btm_c;

  logic                tail_vld_c;
  logic [IDW-1:0]      tail_id_c;
  logic [BWOP-1:0]     tail_c_c;

  logic                rsp_vld_q;
  logic [IDW-1:0]      rsp_id_q;
  logic [BWOP-1:0]     rsp_c_q;

  // A held response freezes the whole pipeline
  assign stall_c = rsp_vld_q & ~i_rsp_rdy;

  // Round-robin pick: valid requester with the smallest distance above the pointer
  always_comb begin
    gnt_c       = '0;
    gnt_idx_c   = '0;
    best_dist_c = NREQ;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (i_req_vld[k] && (((k + NREQ - 32'(ptr_q)) % NREQ) < best_dist_c)) begin
        best_dist_c = (k + NREQ - 32'(ptr_q)) % NREQ;
        gnt_idx_c   = IDW'(k);
      end
    end
    accept_c = (best_dist_c < NREQ) && !stall_c && !i_rst;
    for (int unsigned k = 0; k < NREQ; k++) begin
      gnt_c[k] = accept_c && (gnt_idx_c == IDW'(k));
    end
  end

  assign o_req_rdy = gnt_c;

  // Operand mux for the granted requester
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt_idx_c == IDW'(k)) begin
        sel_a_c = i_req_a[k*BWOP +: BWOP];
        sel_b_c = i_req_b[k*BWOP +: BWOP];
      end
    end
  end

  // Pointer moves just past the accepted requester, otherwise holds
  always_comb begin
    ptr_d = ptr_q;
    if (accept_c) begin
      ptr_d = (gnt_idx_c == IDW'(NREQ - 1)) ? '0 : gnt_idx_c + IDW'(1);
    end
  end

  // Pointer register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Stage 0: capture the accepted request (a bubble when nothing is granted)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s0_vld_q <= 1'b0;
      s0_id_q  <= '0;
      s0_a_q   <= '0;
      s0_b_q   <= '0;
    end else if (!stall_c) begin
      s0_vld_q <= accept_c;
      if (accept_c) begin
        s0_id_q <= gnt_idx_c;
        s0_a_q  <= sel_a_c;
        s0_b_q  <= sel_b_c;
      end
    end
  end

  // btm multiplier: round operands to BWOP-NAB bits, multiply, rescale by 2*NAB
  if (NAB == 0) begin : g_exact
    assign btm_c = BWOP'(PW'(s0_a_q) * PW'(s0_b_q));
  end else begin : g_approx
    localparam int unsigned RW = BWOP - NAB + 1;
    logic [RW-1:0] a_rnd_c;
    logic [RW-1:0] b_rnd_c;
    assign a_rnd_c = RW'(s0_a_q >> NAB) + RW'(s0_a_q[NAB-1]);
    assign b_rnd_c = RW'(s0_b_q >> NAB) + RW'(s0_b_q[NAB-1]);
    assign btm_c   = BWOP'((PW'(a_rnd_c) * PW'(b_rnd_c)) << (2 * NAB));
  end

  // Result stages 1..LAT-1; with LAT=1 the product goes straight to the response
  if (LAT == 1) begin : g_lat1
    assign tail_vld_c = s0_vld_q;
    assign tail_id_c  = s0_id_q;
    assign tail_c_c   = btm_c;
  end else begin : g_latn
    localparam int unsigned NST = LAT - 1;
    logic [NST-1:0]  st_vld_q;
    logic [IDW-1:0]  st_id_q [NST];
    logic [BWOP-1:0] st_c_q  [NST];

    // Shift register of results; bubbles advance with valid entries
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        st_vld_q <= '0;
        for (int unsigned j = 0; j < NST; j++) begin
          st_id_q[j] <= '0;
          st_c_q[j]  <= '0;
        end
      end else if (!stall_c) begin
        st_vld_q[0] <= s0_vld_q;
        if (s0_vld_q) begin
          st_id_q[0] <= s0_id_q;
          st_c_q[0]  <= btm_c;
        end
        for (int unsigned j = 1; j < NST; j++) begin
          st_vld_q[j] <= st_vld_q[j-1];
          if (st_vld_q[j-1]) begin
            st_id_q[j] <= st_id_q[j-1];
            st_c_q[j]  <= st_c_q[j-1];
          end
        end
      end
    end

    assign tail_vld_c = st_vld_q[NST-1];
    assign tail_id_c  = st_id_q[NST-1];
    assign tail_c_c   = st_c_q[NST-1];
  end

  // Response register; data only changes when a new result arrives
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_c_q   <= '0;
    end else if (!stall_c) begin
      rsp_vld_q <= tail_vld_c;
      if (tail_vld_c) begin
        rsp_id_q <= tail_id_c;
        rsp_c_q  <= tail_c_c;
      end
    end
  end

  assign o_rsp_vld = rsp_vld_q;
  assign o_rsp_id  = rsp_id_q;
  assign o_rsp_c   = rsp_c_q;

`ifdef BTM_ARB_STATS_EN
  localparam int unsigned CW = 16;

  logic [CW-1:0]      stall_cnt_q;
  logic [NREQ*CW-1:0] gnt_cnt_q;

  // Saturating stall-cycle and per-requester accept counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
      gnt_cnt_q   <= '0;
    end else begin
      if (stall_c && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + CW'(1);
      end
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (gnt_c[k] && (gnt_cnt_q[k*CW +: CW] != 16'hFFFF)) begin
          gnt_cnt_q[k*CW +: CW] <= gnt_cnt_q[k*CW +: CW] + CW'(1);
        end
      end
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_gnt_cnt   = gnt_cnt_q;
`endif

endmodule

// File: tb/tb_btm_arb.sv
// Scoreboard bench for btm_arb: a reference model predicts grants and products,
// and a negedge monitor checks every response, its latency and hold behaviour.
module tb_btm_arb;

  localparam int unsigned BWOP = 32;
  localparam int unsigned NAB  = 1;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned LAT  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_vld;
  logic [NREQ*BWOP-1:0] req_a;
  logic [NREQ*BWOP-1:0] req_b;
  logic [NREQ-1:0]      req_rdy;
  logic                 rsp_vld;
  logic [IDW-1:0]       rsp_id;
  logic [BWOP-1:0]      rsp_c;
  logic                 rsp_rdy;
`ifdef BTM_ARB_STATS_EN
  logic [15:0]          stall_cnt;
  logic [NREQ*16-1:0]   gnt_cnt;
`endif

  always #5 clk = ~clk;

  btm_arb #(.BWOP(BWOP), .NAB(NAB), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req_vld (req_vld),
    .i_req_a   (req_a),
    .i_req_b   (req_b),
    .o_req_rdy (req_rdy),
    .o_rsp_vld (rsp_vld),
    .o_rsp_id  (rsp_id),
    .o_rsp_c   (rsp_c),
    .i_rsp_rdy (rsp_rdy)
`ifdef BTM_ARB_STATS_EN
    ,
    .o_stall_cnt (stall_cnt),
    .o_gnt_cnt   (gnt_cnt)
`endif
  );

  typedef struct {
    logic [IDW-1:0]  id;
    logic [BWOP-1:0] c;
    int              acc_cyc;
    int              stall_snap;
  } exp_t;

  exp_t            sbq[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              stall_tot = 0;
  int              ptr_m = 0;
  logic            presented = 1'b0;
  logic            hold_chk = 1'b0;
  logic [IDW-1:0]  hold_id;
  logic [BWOP-1:0] hold_c;

  // Reference product: round each operand to nearest at NAB bits, multiply, rescale
  function automatic logic [BWOP-1:0] btm_ref(input logic [BWOP-1:0] a, input logic [BWOP-1:0] b);
    longint unsigned ar, br, p;
    ar = a;
    br = b;
    if (NAB == 0) begin
      p = ar * br;
    end else begin
      ar = (ar >> NAB) + ((ar >> (NAB - 1)) & 64'd1);
      br = (br >> NAB) + ((br >> (NAB - 1)) & 64'd1);
      p  = (ar * br) << (2 * NAB);
    end
    return BWOP'(p);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and reference model, evaluated mid-cycle
  always @(negedge clk) begin : mon
    logic [NREQ-1:0] exp_rdy;
    logic            stall_m;
    logic            found;
    int              gk;
    exp_t            e;
    if (rst) begin
      sbq.delete();
      ptr_m     = 0;
      presented = 1'b0;
      hold_chk  = 1'b0;
      stall_tot = 0;
    end else begin
      if (hold_chk) begin
        chk("hold_vld", 64'(rsp_vld), 64'd1);
        chk("hold_id", 64'(rsp_id), 64'(hold_id));
        chk("hold_c", 64'(rsp_c), 64'(hold_c));
      end
      if (rsp_vld) begin
        if (!presented) begin
          if (sbq.size() == 0) begin
            chk("rsp_unexpected", 64'(rsp_vld), 64'd0);
          end else begin
            e = sbq[0];
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_c", 64'(rsp_c), 64'(e.c));
            chk("rsp_lat", 64'((cyc - e.acc_cyc) - (stall_tot - e.stall_snap)), 64'(LAT));
            presented = 1'b1;
          end
        end
        if (rsp_rdy) begin
          if (presented) void'(sbq.pop_front());
          presented = 1'b0;
          hold_chk  = 1'b0;
        end else begin
          hold_chk = 1'b1;
          hold_id  = rsp_id;
          hold_c   = rsp_c;
        end
      end else begin
        hold_chk = 1'b0;
      end

      stall_m = rsp_vld & ~rsp_rdy;
      exp_rdy = '0;
      found   = 1'b0;
      gk      = 0;
      if (!stall_m) begin
        for (int k = 0; k < int'(NREQ); k++) begin
          if (!found && req_vld[(ptr_m + k) % NREQ]) begin
            found = 1'b1;
            gk    = (ptr_m + k) % NREQ;
          end
        end
      end
      if (found) exp_rdy[gk] = 1'b1;
      chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
      if (found) begin
        e.id         = IDW'(gk);
        e.c          = btm_ref(req_a[gk*BWOP +: BWOP], req_b[gk*BWOP +: BWOP]);
        e.acc_cyc    = cyc + 1;
        e.stall_snap = stall_tot;
        sbq.push_back(e);
        ptr_m = (gk + 1) % NREQ;
      end
      if (stall_m) stall_tot++;
    end
  end

  logic [NREQ-1:0] fair_exp [4];
  int              n;

  initial begin
    fair_exp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    rst     = 1'b1;
    req_vld = '1;
    req_a   = '0;
    req_b   = '0;
    rsp_rdy = 1'b1;
    repeat (3) step();
    // Reset state, including grant suppression while reset is held
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_c", 64'(rsp_c), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    req_vld = '0;
    rst     = 1'b0;
    step();

    // All requesters valid: grants rotate 0,1,2,3,...
    req_vld = '1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        req_a[k*BWOP +: BWOP] = $urandom;
        req_b[k*BWOP +: BWOP] = $urandom;
      end
      #1;
      chk("rr_order", 64'(req_rdy), 64'(1 << (i % 4)));
      step();
    end
    req_vld = '0;
    repeat (LAT + 3) step();

    // Single request from requester 2: 6 x 10 -> 60 after LAT edges
    req_vld[2]             = 1'b1;
    req_a[2*BWOP +: BWOP]  = 32'd6;
    req_b[2*BWOP +: BWOP]  = 32'd10;
    #1;
    for (int i = 0; i < 5 && !req_rdy[2]; i++) step();
    chk("single_rdy", 64'(req_rdy), 64'b0100);
    step();
    req_vld = '0;
    n = 0;
    while (n < 10) begin
      step();
      n++;
      if (rsp_vld) break;
    end
    chk("single_lat", 64'(n), 64'(LAT));
    chk("single_id", 64'(rsp_id), 64'd2);
    chk("single_c", 64'(rsp_c), 64'd60);
    step();
    chk("single_once", 64'(rsp_vld), 64'd0);
    repeat (2) step();

    // Backpressure: hold the response for 5 cycles with all requesters waiting
    req_vld = '1;
    for (int i = 0; i < 10 && !rsp_vld; i++) step();
    chk("bp_vld", 64'(rsp_vld), 64'd1);
    rsp_rdy = 1'b0;
    repeat (5) step();
`ifdef BTM_ARB_STATS_EN
    chk("stall_cnt", 64'(stall_cnt), 64'd5);
`endif
    rsp_rdy = 1'b1;
    req_vld = '0;
    repeat (LAT + 6) step();

    // Reset with two operations in flight, then fairness between 1 and 3
    req_vld = '1;
    repeat (2) step();
    rst = 1'b1;
    #1;
    chk("midrst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("midrst_req_rdy", 64'(req_rdy), 64'd0);
    step();
    rst     = 1'b0;
    req_vld = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fair_gnt", 64'(req_rdy), 64'(fair_exp[i]));
      step();
    end
    req_vld = '0;
    repeat (LAT + 4) step();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      req_vld = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int k = 0; k < int'(NREQ); k++) begin
        req_a[k*BWOP +: BWOP] = ($urandom_range(0, 3) == 0) ? BWOP'($urandom_range(0, 255)) : $urandom;
        req_b[k*BWOP +: BWOP] = ($urandom_range(0, 3) == 0) ? BWOP'($urandom_range(0, 255)) : $urandom;
      end
      rsp_rdy = ($urandom_range(0, 3) != 0);
      step();
    end

    // Drain every outstanding response
    req_vld = '0;
    rsp_rdy = 1'b1;
    for (int i = 0; i < 50 && (sbq.size() != 0 || rsp_vld); i++) step();
    chk("drain_pending", 64'(sbq.size()), 64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btm_arb.md
Name: btm_arb

Overview:
- Round-robin arbiter and pipeline controller that shares one btm approximate multiplier among NREQ requesters.
- Each requester presents an operand pair with a valid/ready handshake. The winner's operands are registered into btm, and the product flows through a stallable result pipeline.
- The result leaves on a single response channel tagged with the requester ID.
- Sits between accelerator lanes and the approximate-arithmetic datapath.

Parameters:
- BWOP, 32, operand and result width passed to btm.
- NAB, 1, approximate bits passed to btm.
- NREQ, 4, number of requesters (2..16).
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.
- LAT, 2, accept-to-response latency in cycles (1..8).

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_req_vld  input  NREQ  per-requester request valid.
- i_req_a  input  NREQ*BWOP  packed operand A; requester k at [k*BWOP +: BWOP].
- i_req_b  input  NREQ*BWOP  packed operand B, same packing.
- o_req_rdy  output  NREQ  one-hot grant/ready; request k is accepted when i_req_vld[k] & o_req_rdy[k].
- o_rsp_vld  output  1  response valid.
- o_rsp_id  output  IDW  requester index of the response.
- o_rsp_c  output  BWOP  btm product.
- i_rsp_rdy  input  1  response consumer ready.

Behaviour:
- Reset (async, immediate):
  - o_rsp_vld=0, o_rsp_id=0, o_rsp_c=0, o_req_rdy=0.
  - All pipeline valid bits cleared.
  - Round-robin pointer = 0.
  - Any in-flight operation is discarded and produces no response.
- Pipeline structure:
  - Stage 0 registers {vld, id, a, b}.
  - The btm instance is fed combinationally from stage 0.
  - Stages 1..LAT-1 register {vld, id, c}. The last stage drives o_rsp_*.
  - For LAT=1, stage 0 outputs go through btm straight to the o_rsp_* registers; response data is always registered.
- Stall and advance:
  - stall = o_rsp_vld & ~i_rsp_rdy.
  - When stall is high, every stage holds.
  - When stall is low, all stages shift one position; bubbles shift too (no bubble collapsing).
- Arbitration (combinational from i_req_vld, pointer, and stall):
  - With stall low, grant the first requester with i_req_vld set, searching from the pointer upward with wrap at NREQ-1 -> 0.
  - o_req_rdy is the one-hot grant.
  - With stall high, or with no valid requester, o_req_rdy=0.
  - o_req_rdy never depends on i_req_a or i_req_b.
- Pointer update:
  - On an accepted grant to k, the pointer becomes (k+1) mod NREQ.
  - With no grant, the pointer holds.
- Latency:
  - Request accepted at edge T gives o_rsp_vld=1 with that request's id and c after edge T+LAT, provided there is no stall.
  - Each stalled cycle adds one cycle.
- Throughput and order:
  - One accept per cycle when unstalled.
  - Responses come out in accept order.
- Handshake rules:
  - o_rsp_id and o_rsp_c stay stable while o_rsp_vld=1 and i_rsp_rdy=0.
  - A requester may drop i_req_vld without being granted; no state changes.
- Arithmetic:
  - o_rsp_c equals btm(a,b) for the same BWOP and NAB: operands are rounded to BWOP-NAB bits, multiplied, then shifted left by 2*NAB and truncated to BWOP.
  - With NAB=0 the result is the low BWOP bits of a*b.
- Boundary cases:
  - All NREQ valid continuously: grants rotate 0,1,...,NREQ-1,0,... with no requester starved for more than NREQ-1 accepts.
  - A simultaneous accept and response (i_rsp_rdy=1) in the same cycle is legal and loses no data.

Optional Feature:
- Macro BTM_ARB_STATS_EN.
- When defined, the block adds:
  - Output o_stall_cnt (16 bits): counts cycles with stall=1.
  - Output o_gnt_cnt (NREQ*16 bits): per-requester accepted-request counts.
  - Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, neither port nor the counter logic exists. All other behaviour is identical.

Test Plan:
- Single request, NAB=1, LAT=2: requester 2 sends a=6, b=10, i_rsp_rdy=1 -> accepted at T; o_rsp_vld=1, o_rsp_id=2, o_rsp_c=60 after edge T+2; one response only.
- All four requesters valid for 8 cycles with i_rsp_rdy=1 -> grant order 0,1,2,3,0,1,2,3; responses in the same order, each LAT cycles after its accept.
- Backpressure: i_rsp_rdy=0 for 5 cycles while a response is valid -> o_req_rdy=0 throughout; o_rsp_c held stable; after release, the queued responses emerge on consecutive cycles with none lost or duplicated.
- Pointer fairness: requesters 1 and 3 valid continuously, pointer starts at 0 -> grants 1,3,1,3.
- Reset mid-flight: assert i_rst with 2 ops in the pipeline -> o_rsp_vld=0 immediately and no stale response after release; the first post-reset grant goes to the lowest valid index from pointer 0.
- NAB=0 build: a=32'hFFFF_FFFF, b=2 -> o_rsp_c=32'hFFFF_FFFE. With BTM_ARB_STATS_EN defined, after the backpressure test o_stall_cnt=5.
